// File: rtl/bubble_sort_unit.sv
// bubble_sort_unit: method-call callee that bubble-sorts an internal signed
// array (ascending), re-reads it to verify ordering, and returns pass/fail
// plus the number of swaps performed.
// Optional: define BUBBLE_SORT_EARLY_EXIT_EN to stop after a pass with no swaps.
module bubble_sort_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sort_req,
  output logic             sort_busy,
  output logic             sort_return,
  output logic [31:0]      swap_count,
  input  logic [AW-1:0]    data_address,
  input  logic [WIDTH-1:0] data_din,
  input  logic             data_we,
  output logic [WIDTH-1:0] data_dout,
  input  logic             finish_flag_in,
  input  logic             finish_flag_we,
  output logic             finish_flag_out
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_RD0, S_RD1, S_CMP, S_WR0, S_WR1, S_CHK, S_DONE
  } state_t;

  localparam logic [AW-1:0] I_START = AW'(DEPTH - 1);
  localparam logic [AW:0]   K_LAST  = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];
  state_t           r_state;
  logic             r_busy;
  logic             r_return;
  logic [31:0]      r_swaps;
  logic [WIDTH-1:0] r_dout;
  logic             r_flag;
  logic [AW-1:0]    r_i;
  logic [AW-1:0]    r_j;
  logic [AW:0]      r_k;
  logic [WIDTH-1:0] r_rd;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_prev;
  logic             r_ok;
  logic             r_pass_sw;

  logic [AW-1:0]    w_addr;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;
  state_t           w_adv_state;
  logic [AW-1:0]    w_adv_i;
  logic [AW-1:0]    w_adv_j;
  logic             w_adv_clr;
  logic             w_swapped;

  // Single memory port: select read address and write request by state
  always_comb begin
    w_addr  = r_j;
    w_we    = 1'b0;
    w_waddr = data_address;
    w_wdata = data_din;
    case (r_state)
      S_IDLE: begin
        w_addr = data_address;
        w_we   = data_we;
      end
      S_RD0:  w_addr = r_j;
      S_RD1:  w_addr = r_j + 1'b1;
      S_CHK:  w_addr = r_k[AW-1:0];
      S_WR0: begin
        w_we    = 1'b1;
        w_waddr = r_j;
        w_wdata = r_b;
      end
      S_WR1: begin
        w_we    = 1'b1;
        w_waddr = r_j + 1'b1;
        w_wdata = r_a;
      end
      default: ;
    endcase
  end

  // Loop advance after a compare (CMP) or a completed swap (WR1)
  always_comb begin
    // a swap finishing this cycle counts for the current pass
    w_swapped   = r_pass_sw | (r_state == S_WR1);
    w_adv_state = S_RD0;
    w_adv_i     = r_i;
    w_adv_j     = r_j + 1'b1;
    w_adv_clr   = 1'b0;
    if (r_j < r_i - 1'b1) begin
      w_adv_state = S_RD0;
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
    end else if (!w_swapped) begin
      w_adv_state = S_CHK;
      w_adv_j     = r_j;
`endif
    end else if (r_i > AW'(1)) begin
      w_adv_i   = r_i - 1'b1;
      w_adv_j   = '0;
      w_adv_clr = 1'b1;
    end else begin
      w_adv_state = S_CHK;
      w_adv_j     = r_j;
    end
  end

  // Array storage: not cleared by reset, write blocked while reset is high
  always_ff @(posedge clk) begin
    if (!reset && w_we && (int'(w_waddr) < DEPTH))
      r_mem[w_waddr] <= w_wdata;
  end

  // Registered read port, one cycle latency
  always_ff @(posedge clk) begin
    r_rd <= r_mem[w_addr];
  end

  // Method FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_return  <= 1'b0;
      r_swaps   <= '0;
      r_dout    <= '0;
      r_flag    <= 1'b0;
      r_i       <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_prev    <= '0;
      r_ok      <= 1'b0;
      r_pass_sw <= 1'b0;
    end else begin
      if (finish_flag_we) r_flag <= finish_flag_in;
      case (r_state)
        S_IDLE: begin
          r_dout <= r_mem[w_addr];
          if (sort_req) begin
            r_state <= S_INIT;
            r_busy  <= 1'b1;
          end
        end
        S_INIT: begin
          r_i       <= I_START;
          r_j       <= '0;
          r_k       <= '0;
          r_swaps   <= '0;
          r_pass_sw <= 1'b0;
          r_ok      <= 1'b1;
          r_state   <= S_RD0;
        end
        S_RD0: r_state <= S_RD1;
        S_RD1: begin
          r_a     <= r_rd;
          r_state <= S_CMP;
        end
        S_CMP: begin
          r_b <= r_rd;
          if ($signed(r_a) > $signed(r_rd)) begin
            r_state <= S_WR0;
          end else begin
            r_state <= w_adv_state;
            r_i     <= w_adv_i;
            r_j     <= w_adv_j;
            if (w_adv_clr) r_pass_sw <= 1'b0;
          end
        end
        S_WR0: r_state <= S_WR1;
        S_WR1: begin
          r_swaps   <= r_swaps + 32'd1;
          r_pass_sw <= 1'b1;
          r_state   <= w_adv_state;
          r_i       <= w_adv_i;
          r_j       <= w_adv_j;
          if (w_adv_clr) r_pass_sw <= 1'b0;
        end
        // read k is issued at step k; data for k-1 arrives at step k
        S_CHK: begin
          r_k <= r_k + 1'b1;
          if (r_k >= (AW+1)'(1)) r_prev <= r_rd;
          if (r_k >= (AW+1)'(2) && $signed(r_rd) < $signed(r_prev)) r_ok <= 1'b0;
          if (r_k == K_LAST) r_state <= S_DONE;
        end
        S_DONE: begin
          r_return <= r_ok;
          r_flag   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sort_busy       = r_busy;
  assign sort_return     = r_return;
  assign swap_count      = r_swaps;
  assign data_dout       = r_dout;
  assign finish_flag_out = r_flag;

endmodule

// File: tb/tb_bubble_sort_unit.sv
// Directed self-checking bench for bubble_sort_unit.
module tb_bubble_sort_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        sort_req;
  logic        sort_busy;
  logic        sort_return;
  logic [31:0] swap_count;
  logic [2:0]  data_address;
  logic [31:0] data_din;
  logic        data_we;
  logic [31:0] data_dout;
  logic        finish_flag_in;
  logic        finish_flag_we;
  logic        finish_flag_out;

  int checks = 0;
  int errors = 0;
  int cyc;

  logic [31:0] v_rev  [8];
  logic [31:0] v_asc  [8];
  logic [31:0] v_sgn  [8];
  logic [31:0] v_sgnx [8];

  bubble_sort_unit #(.WIDTH(32), .DEPTH(8), .AW(3)) dut (
    .clk(clk), .reset(reset),
    .sort_req(sort_req), .sort_busy(sort_busy), .sort_return(sort_return),
    .swap_count(swap_count),
    .data_address(data_address), .data_din(data_din), .data_we(data_we),
    .data_dout(data_dout),
    .finish_flag_in(finish_flag_in), .finish_flag_we(finish_flag_we),
    .finish_flag_out(finish_flag_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_mem(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    data_we = 1'b1; data_address = a; data_din = d;
    @(negedge clk);
    data_we = 1'b0;
  endtask

  task automatic load8(input logic [31:0] v [8]);
    for (int i = 0; i < 8; i++) write_mem(3'(i), v[i]);
  endtask

  task automatic read_mem(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    data_address = a;
    @(negedge clk);
    d = data_dout;
  endtask

  task automatic check_array(input string tag, input logic [31:0] v [8]);
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      read_mem(3'(i), d);
      chk($sformatf("%s[%0d]", tag, i), d, v[i]);
    end
  endtask

  // Pulse sort_req for one edge and count the cycles busy stays high
  task automatic run_sort(output int n);
    @(negedge clk);
    sort_req = 1'b1;
    @(negedge clk);
    sort_req = 1'b0;
    chk("busy_rise", {31'b0, sort_busy}, 32'd1);
    n = 0;
    while (sort_busy === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 2000) chk("busy_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      v_rev[i] = 32'(7 - i);
      v_asc[i] = 32'(i);
    end
    v_sgn[0] = 32'hFFFF_FFFF; v_sgn[1] = 32'd5;        v_sgn[2] = 32'hFFFF_8000;
    v_sgn[3] = 32'd3;         v_sgn[4] = 32'd0;        v_sgn[5] = 32'd0;
    v_sgn[6] = 32'h7FFF_FFFF; v_sgn[7] = 32'h8000_0000;
    v_sgnx[0] = 32'h8000_0000; v_sgnx[1] = 32'hFFFF_8000; v_sgnx[2] = 32'hFFFF_FFFF;
    v_sgnx[3] = 32'd0;         v_sgnx[4] = 32'd0;         v_sgnx[5] = 32'd3;
    v_sgnx[6] = 32'd5;         v_sgnx[7] = 32'h7FFF_FFFF;

    reset = 1'b1; sort_req = 1'b0; data_address = '0; data_din = '0; data_we = 1'b0;
    finish_flag_in = 1'b0; finish_flag_we = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy",   {31'b0, sort_busy},       32'd0);
    chk("rst_return", {31'b0, sort_return},     32'd0);
    chk("rst_swaps",  swap_count,               32'd0);
    chk("rst_dout",   data_dout,                32'd0);
    chk("rst_flag",   {31'b0, finish_flag_out}, 32'd0);
    reset = 1'b0;

    // Reverse order: every comparison swaps
    load8(v_rev);
    run_sort(cyc);
    chk("rev_busy_cycles", 32'(cyc), 32'd151);
    chk("rev_return", {31'b0, sort_return}, 32'd1);
    chk("rev_swaps", swap_count, 32'd28);
    chk("rev_flag", {31'b0, finish_flag_out}, 32'd1);
    check_array("rev_rd", v_asc);

    // Already sorted
    load8(v_asc);
    run_sort(cyc);
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
    chk("asc_busy_cycles", 32'(cyc), 32'd32);
`else
    chk("asc_busy_cycles", 32'(cyc), 32'd95);
`endif
    chk("asc_swaps", swap_count, 32'd0);
    chk("asc_return", {31'b0, sort_return}, 32'd1);

    // Signed extremes: 14 inversions
    load8(v_sgn);
    run_sort(cyc);
`ifndef BUBBLE_SORT_EARLY_EXIT_EN
    chk("sgn_busy_cycles", 32'(cyc), 32'd123);
`endif
    chk("sgn_swaps", swap_count, 32'd14);
    chk("sgn_return", {31'b0, sort_return}, 32'd1);
    check_array("sgn_rd", v_sgnx);

    // Reset 40 cycles into a run
    load8(v_rev);
    @(negedge clk);
    sort_req = 1'b1;
    @(negedge clk);
    sort_req = 1'b0;
    repeat (39) @(negedge clk);
    chk("mid_busy_before", {31'b0, sort_busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy",   {31'b0, sort_busy},   32'd0);
    chk("mid_rst_return", {31'b0, sort_return}, 32'd0);
    chk("mid_rst_swaps",  swap_count,           32'd0);
    reset = 1'b0;
    run_sort(cyc);
    chk("after_rst_return", {31'b0, sort_return}, 32'd1);
    check_array("after_rst_rd", v_asc);

    // sort_req held high: back-to-back runs with a single idle cycle
    load8(v_rev);
    @(negedge clk);
    sort_req = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (sort_busy === 1'b1 && cyc < 2000) begin
      cyc++;
      @(negedge clk);
    end
    chk("hold_run1_cycles", 32'(cyc), 32'd151);
    chk("hold_run1_swaps", swap_count, 32'd28);
    chk("hold_gap_low", {31'b0, sort_busy}, 32'd0);
    @(negedge clk);
    chk("hold_gap_rerise", {31'b0, sort_busy}, 32'd1);
    sort_req = 1'b0;
    cyc = 0;
    while (sort_busy === 1'b1 && cyc < 2000) begin
      cyc++;
      @(negedge clk);
    end
`ifdef BUBBLE_SORT_EARLY_EXIT_EN
    chk("hold_run2_cycles", 32'(cyc), 32'd32);
`else
    chk("hold_run2_cycles", 32'(cyc), 32'd95);
`endif
    chk("hold_run2_swaps", swap_count, 32'd0);
    chk("hold_run2_return", {31'b0, sort_return}, 32'd1);

    // External write while busy is ignored
    @(negedge clk);
    sort_req = 1'b1;
    @(negedge clk);
    sort_req = 1'b0;
    data_we = 1'b1; data_address = 3'd2; data_din = 32'd99;
    repeat (5) @(negedge clk);
    data_we = 1'b0;
    cyc = 0;
    while (sort_busy === 1'b1 && cyc < 2000) begin
      cyc++;
      @(negedge clk);
    end
    chk("busy_wr_done", {31'b0, sort_busy}, 32'd0);
    check_array("busy_wr_rd", v_asc);

    // Flag field write after DONE
    chk("flag_set", {31'b0, finish_flag_out}, 32'd1);
    @(negedge clk);
    finish_flag_we = 1'b1; finish_flag_in = 1'b0;
    @(negedge clk);
    finish_flag_we = 1'b0;
    chk("flag_clear", {31'b0, finish_flag_out}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
